// File: rtl/axi_resp_pkg.sv
// axi_resp_pkg: shared collector state encoding and AXI RRESP codes
package axi_resp_pkg;
  typedef enum logic [1:0] {FREE, COLLECT, QUEUED, SEND} col_state_e;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
endpackage

// File: rtl/response_collector_slot.sv
// response_collector_slot: one burst collector holding id, beat payload/resp, count and overflow flag
module response_collector_slot
  import axi_resp_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BEATS  = 16,
  parameter int CW         = $clog2(MAX_BEATS + 1),
  parameter int IW         = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr,
  input  logic                  i_alloc,
  input  logic                  i_last,
  input  logic [ID_WIDTH-1:0]   i_id,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [1:0]            i_resp,
  input  logic                  i_start,
  input  logic                  i_free,
  input  logic [IW-1:0]         i_rd_idx,
  output col_state_e            o_state,
  output logic [ID_WIDTH-1:0]   o_id,
  output logic [CW-1:0]         o_count,
  output logic                  o_ovf,
  output logic                  o_ovf_pulse,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_resp
);
  col_state_e            r_state;
  logic [ID_WIDTH-1:0]   r_id;
  logic [CW-1:0]         r_count;
  logic                  r_ovf;
  logic                  r_ovf_pulse;
  logic [DATA_WIDTH-1:0] r_data [1<<IW];
  logic [1:0]            r_resp [1<<IW];
  logic [CW-1:0]         w_idx;
  logic                  w_full;

  assign w_idx  = i_alloc ? '0 : r_count;
  assign w_full = w_idx == CW'(MAX_BEATS);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FREE;
      r_id        <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_ovf_pulse <= 1'b0;
    end else begin
      r_ovf_pulse <= i_wr & w_full & ~r_ovf;
      if (i_wr) begin
        r_state <= i_last ? QUEUED : COLLECT;
        if (i_alloc) r_id <= i_id;
        r_count <= w_full ? r_count : w_idx + 1'b1;
        r_ovf   <= (~i_alloc & r_ovf) | w_full;
      end else if (i_start) r_state <= SEND;
      else if (i_free) r_state <= FREE;
    end
  end

  // Beats past MAX_BEATS are swallowed; only the sticky ovf flag records them
  always_ff @(posedge clk) begin
    if (i_wr & ~w_full) begin
      r_data[w_idx[IW-1:0]] <= i_data;
      r_resp[w_idx[IW-1:0]] <= i_resp;
    end
  end

  assign o_state     = r_state;
  assign o_id        = r_id;
  assign o_count     = r_count;
  assign o_ovf       = r_ovf;
  assign o_ovf_pulse = r_ovf_pulse;
  assign o_data      = r_data[i_rd_idx];
  assign o_resp      = r_resp[i_rd_idx];
endmodule

// File: rtl/interleaved_response_buffer.sv
// interleaved_response_buffer: assembles interleaved R bursts in collectors and streams them whole in completion order
module interleaved_response_buffer
  import axi_resp_pkg::*;
#(
  parameter int ID_WIDTH       = 4,
  parameter int DATA_WIDTH     = 64,
  parameter int MAX_BEATS      = 16,
  parameter int NUM_COLLECTORS = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [ID_WIDTH-1:0]                   s_id,
  input  logic [DATA_WIDTH-1:0]                 s_data,
  input  logic [1:0]                            s_resp,
  input  logic                                  s_last,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [ID_WIDTH-1:0]                   m_id,
  output logic [DATA_WIDTH-1:0]                 m_data,
  output logic [1:0]                            m_resp,
  output logic                                  m_last,
  output logic [$clog2(NUM_COLLECTORS+1)-1:0]   occupancy,
  output logic                                  overflow_err
);
  localparam int N  = NUM_COLLECTORS;
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam int IW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int OW = $clog2(N + 1);

  col_state_e            w_state [N];
  logic [ID_WIDTH-1:0]   w_id    [N];
  logic [CW-1:0]         w_count [N];
  logic [DATA_WIDTH-1:0] w_data  [N];
  logic [1:0]            w_resp  [N];
  logic [N-1:0]          w_ovf, w_pulse, w_match, w_freev, w_wr, w_alloc, w_start, w_free;
  logic [SW-1:0]         w_free_idx, w_match_idx, w_push_idx, w_head;
  logic                  w_hit, w_acc, w_push, w_pop, w_begin;
  logic [SW-1:0]         r_q [N];
  logic [SW-1:0]         r_wp, r_rp;
  logic [OW-1:0]         r_qcnt, r_occ;
  logic                  r_busy;
  logic [CW-1:0]         r_idx;

  function automatic logic [SW-1:0] nxt(input logic [SW-1:0] p);
    return (p == SW'(N - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_free_idx  = '0;
    w_match_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_freev[i]) w_free_idx = SW'(i);
      if (w_match[i]) w_match_idx = SW'(i);
    end
  end

  assign w_hit      = |w_match;
  assign s_ready    = w_hit | (|w_freev);
  assign w_acc      = s_valid & s_ready;
  assign w_push     = w_acc & s_last;
  assign w_push_idx = w_hit ? w_match_idx : w_free_idx;
  assign w_head     = r_q[r_rp];
  assign w_begin    = ~r_busy & (r_qcnt != '0);
  assign w_pop      = r_busy & m_ready & m_last;

  for (genvar g = 0; g < N; g++) begin : g_slot
    assign w_match[g] = (w_state[g] == COLLECT) && (w_id[g] == s_id);
    assign w_freev[g] = w_state[g] == FREE;
    assign w_alloc[g] = w_acc & ~w_hit & (w_free_idx == SW'(g));
    assign w_wr[g]    = w_alloc[g] | (w_acc & w_match[g]);
    assign w_start[g] = w_begin & (w_head == SW'(g));
    assign w_free[g]  = w_pop & (w_head == SW'(g));
    response_collector_slot #(
      .ID_WIDTH(ID_WIDTH), .DATA_WIDTH(DATA_WIDTH), .MAX_BEATS(MAX_BEATS), .CW(CW), .IW(IW)
    ) u_slot (
      .clk(clk), .rst(rst), .i_wr(w_wr[g]), .i_alloc(w_alloc[g]), .i_last(s_last),
      .i_id(s_id), .i_data(s_data), .i_resp(s_resp), .i_start(w_start[g]), .i_free(w_free[g]),
      .i_rd_idx(r_idx[IW-1:0]), .o_state(w_state[g]), .o_id(w_id[g]), .o_count(w_count[g]),
      .o_ovf(w_ovf[g]), .o_ovf_pulse(w_pulse[g]), .o_data(w_data[g]), .o_resp(w_resp[g])
    );
  end

  // Completion queue holds slot indices; N slots bound its depth so it never overflows
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_qcnt <= '0;
      r_occ  <= '0;
      r_busy <= 1'b0;
      r_idx  <= '0;
    end else begin
      if (w_push) begin
        r_q[r_wp] <= w_push_idx;
        r_wp      <= nxt(r_wp);
      end
      if (w_pop) r_rp <= nxt(r_rp);
      r_qcnt <= r_qcnt + OW'(w_push) - OW'(w_pop);
      r_occ  <= r_occ + OW'(|w_alloc) - OW'(w_pop);
      if (w_begin) begin
        r_busy <= 1'b1;
        r_idx  <= '0;
      end else if (w_pop) r_busy <= 1'b0;
      else if (r_busy & m_ready) r_idx <= r_idx + 1'b1;
    end
  end

  assign m_valid      = r_busy;
  assign m_last       = r_busy & (r_idx == w_count[w_head] - 1'b1);
  assign m_id         = r_busy ? w_id[w_head] : '0;
  assign m_data       = r_busy ? w_data[w_head] : '0;
  assign m_resp       = ~r_busy ? OKAY : (w_ovf[w_head] & m_last) ? SLVERR : w_resp[w_head];
  assign occupancy    = r_occ;
  assign overflow_err = |w_pulse;
endmodule

// File: doc/interleaved_response_buffer.md
Name: interleaved_response_buffer

Overview:
- Multi-collector R-channel burst buffer between the AXI slave R port and the r_id_ordering_unit.
- Accepts R beats whose RIDs may be interleaved across bursts, and assembles each burst in its own collector.
- Streams whole bursts out in burst-completion order, never interleaved on the output.
- Adds over the single-collector buffer: per-beat RRESP storage, MAX_BEATS overflow handling, and an occupancy status output.

Parameters:
- ID_WIDTH, 4, RID width.
- DATA_WIDTH, 64, RDATA width.
- MAX_BEATS, 16, beats storable per collector.
- NUM_COLLECTORS, 4, concurrent bursts held (in collection or awaiting output); must be ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat ready.
- s_id  in  ID_WIDTH  RID.
- s_data  in  DATA_WIDTH  RDATA.
- s_resp  in  2  RRESP.
- s_last  in  1  RLAST.
- m_valid  out  1  output beat valid.
- m_ready  in  1  output beat ready.
- m_id  out  ID_WIDTH  burst ID.
- m_data  out  DATA_WIDTH  beat data.
- m_resp  out  2  stored per-beat RRESP.
- m_last  out  1  last beat of burst.
- occupancy  out  $clog2(NUM_COLLECTORS+1)  collectors not FREE.
- overflow_err  out  1  one-cycle pulse: burst exceeded MAX_BEATS.

Behaviour:
- Collector state per slot: FREE, COLLECT, QUEUED, SEND. Each slot holds:
  - id;
  - beat count, $clog2(MAX_BEATS+1) bits;
  - MAX_BEATS×DATA_WIDTH payload;
  - MAX_BEATS×2 resp array;
  - sticky ovf bit.
- Beat routing:
  - A beat goes to the unique slot in COLLECT whose id == s_id.
  - If no slot matches, allocate the lowest-index FREE slot: it enters COLLECT, id ← s_id, beat stored at index 0.
  - Slots in QUEUED or SEND are never matched. A new burst with the same ID allocates a fresh slot.
- s_ready:
  - High when a matching COLLECT slot exists, or a FREE slot exists.
  - Low otherwise, i.e. a new ID arrives with every slot busy.
  - Combinational from s_id and slot state; no dependence on s_valid.
- Storing beats:
  - Accepted beat with count < MAX_BEATS: data and resp stored at index count; count increments.
  - Accepted beat with count == MAX_BEATS: accepted but not stored. ovf set; overflow_err pulses the next cycle (once per burst).
- Commit:
  - An accepted beat with s_last=1 moves the slot COLLECT→QUEUED at the clock edge.
  - The slot index is pushed into the completion queue, a FIFO of depth NUM_COLLECTORS, which cannot overflow.
  - Same-cycle allocate + last (single-beat burst) goes FREE→QUEUED directly with count=1.
- Output:
  - When idle and the queue is non-empty, the head slot goes QUEUED→SEND and the beat index resets to 0; m_valid rises the following cycle.
  - m_data, m_resp, m_id come from the head slot at the beat index.
  - m_last = (index == count−1).
  - If ovf is set, m_resp on the final beat is forced to 2'b10 (SLVERR).
  - The index advances on m_valid & m_ready.
  - On the last-beat handshake: slot → FREE, queue pops, m_valid drops for one cycle before the next burst.
- Outputs must hold stable while m_valid & ~m_ready.
- Latency: last input beat accepted at edge T → slot QUEUED after T → SEND after T+1 → m_valid high in cycle T+2 with an empty pipeline.
- Simultaneous events:
  - A slot freed at edge T can be allocated by a beat in cycle T+1, not in the cycle it is freeing.
  - Input commit and output pop in the same cycle are both honoured; queue count is unchanged.
- occupancy is registered: number of non-FREE slots, updated each edge.
- Reset (including mid-burst): all slots FREE, counts 0, queue empty. m_valid=0, m_last=0, m_id/m_data/m_resp=0, overflow_err=0, occupancy=0. s_ready=1 in the cycle after reset deasserts. Partial bursts are discarded.

Decomposition:
- Shared package (axi_resp_pkg):
  - col_state_e enum {FREE, COLLECT, QUEUED, SEND};
  - resp constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
- One natural sub-module: response_collector_slot, holding the per-slot state, storage, count, ovf, and write/read ports. It is instantiated NUM_COLLECTORS times via generate.
- Allocator, ID match, completion queue and output sequencer stay in the top level.

Test Plan:
- Single burst ID=3, 4 beats D0..D3 resp OKAY, m_ready=1 → m beats D0..D3, m_id=3, m_last on 4th only, m_valid first high 2 cycles after input last.
- Interleaved ID1/ID2 beats (A0,B0,A1,B1 with last) where ID2 finishes first → output ID2's full burst first, then ID1's burst contiguously, never interleaved.
- NUM_COLLECTORS=4 with 4 open IDs and a 5th ID beat → s_ready=0 until one burst fully drains. A beat for an already-open ID while full → s_ready=1.
- 18-beat burst with MAX_BEATS=16 → 16 beats out, final resp=SLVERR, overflow_err single pulse, all 18 input beats accepted.
- Per-beat resp OKAY,SLVERR,OKAY → m_resp reproduces the sequence. m_ready toggled randomly → outputs stable while stalled.
- Assert rst mid-collection and mid-send → next cycle m_valid=0, occupancy=0, s_ready=1. A subsequent burst passes cleanly.
